// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer: FSM states,
// config register addresses and register reset values.
package counter_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_WRAP = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    localparam logic [1:0] CFG_START  = 2'd0;
    localparam logic [1:0] CFG_END    = 2'd1;
    localparam logic [1:0] CFG_REPEAT = 2'd2;
    localparam logic [1:0] CFG_PRESC  = 2'd3;

    // Wide constants; each register takes the low bits it needs.
    localparam logic [31:0] START_RST  = 32'd0;
    localparam logic [31:0] END_RST    = 32'hFFFF_FFFF;
    localparam logic [31:0] REPEAT_RST = 32'd1;
    localparam logic [31:0] PRESC_RST  = 32'd0;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Config, control and counter-side signals of the counter sequencer.
// master = decode/counter side, slave = the sequencer.
interface counter_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
);
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [WIDTH-1:0] cfg_wdata;
    logic             go;
    logic             abort;
    logic [WIDTH-1:0] cnt_val;
    logic             cnt_load_en;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_inc_en;
    logic             busy;
    logic             wrap;
    logic             done;
    logic [REP_W-1:0] pass_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, go, abort, cnt_val,
        input  cnt_load_en, cnt_load_val, cnt_inc_en, busy, wrap, done, pass_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, go, abort, cnt_val,
        output cnt_load_en, cnt_load_val, cnt_inc_en, busy, wrap, done, pass_cnt
    );
endinterface

// File: rtl/counter_seq_presc.sv
// Prescaler tick generator: counts 0..presc and ticks on the terminal count.
// clr holds it at phase 0, freeze holds the current phase and masks the tick.
module counter_seq_presc #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               freeze,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);
    logic [PRESC_W-1:0] cnt;

    assign tick = !clr && !freeze && (cnt == presc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!freeze) begin
            cnt <= (cnt == presc) ? '0 : cnt + PRESC_W'(1);
        end
    end
endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer driving load/increment enables of the shared up-counter.
// Optional macro COUNTER_SEQ_PAUSE_EN adds a pause input that freezes RUN.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int REP_W   = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef COUNTER_SEQ_PAUSE_EN
    input  logic               pause,
`endif
    counter_seq_ctrl_if.slave  bus
);
    logic [WIDTH-1:0]   start_val;
    logic [WIDTH-1:0]   end_val;
    logic [REP_W-1:0]   repeat_val;
    logic [PRESC_W-1:0] presc_val;

    seq_state_t         state;
    logic [REP_W-1:0]   pass_cnt_q;
    logic               load_en_q;
    logic               busy_q;
    logic               wrap_q;
    logic               done_q;

    logic               tick;
    logic               freeze;
    logic               presc_clr;
    logic               at_end;

    function automatic logic [REP_W-1:0] sat_inc(input logic [REP_W-1:0] v);
        return (&v) ? v : v + REP_W'(1);
    endfunction

    // Config registers are writable only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_val  <= START_RST[WIDTH-1:0];
            end_val    <= END_RST[WIDTH-1:0];
            repeat_val <= REPEAT_RST[REP_W-1:0];
            presc_val  <= PRESC_RST[PRESC_W-1:0];
        end else if (bus.cfg_we && state == ST_IDLE) begin
            case (bus.cfg_addr)
                CFG_START:  start_val  <= bus.cfg_wdata;
                CFG_END:    end_val    <= bus.cfg_wdata;
                CFG_REPEAT: repeat_val <= bus.cfg_wdata[REP_W-1:0];
                CFG_PRESC:  presc_val  <= bus.cfg_wdata[PRESC_W-1:0];
                default:    ;
            endcase
        end
    end

`ifdef COUNTER_SEQ_PAUSE_EN
    assign freeze = pause;
`else
    assign freeze = 1'b0;
`endif

    assign presc_clr = (state != ST_RUN);

    counter_seq_presc #(.PRESC_W(PRESC_W)) u_presc (
        .clk    (clk),
        .rst    (rst),
        .clr    (presc_clr),
        .freeze (freeze),
        .presc  (presc_val),
        .tick   (tick)
    );

    assign at_end = (bus.cnt_val == end_val);

    // Pass counter advances on entry to WRAP so it is visible with the wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pass_cnt_q <= '0;
            load_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            load_en_q <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            if (state != ST_IDLE && bus.abort) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.go && !bus.abort) begin
                            state      <= ST_LOAD;
                            pass_cnt_q <= '0;
                            load_en_q  <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                    ST_LOAD: state <= ST_RUN;
                    ST_RUN: begin
                        if (tick && at_end) begin
                            state      <= ST_WRAP;
                            wrap_q     <= 1'b1;
                            pass_cnt_q <= sat_inc(pass_cnt_q);
                        end
                    end
                    ST_WRAP: begin
                        if (repeat_val != '0 && pass_cnt_q == repeat_val) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= ST_LOAD;
                            load_en_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.cnt_load_en  = load_en_q;
    assign bus.cnt_load_val = start_val;
    assign bus.cnt_inc_en   = (state == ST_RUN) && tick && !at_end;
    assign bus.busy         = busy_q;
    assign bus.wrap         = wrap_q;
    assign bus.done         = done_q;
    assign bus.pass_cnt     = pass_cnt_q;
endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer for the shared 8-bit loadable up-counter datapath. It drives the counter's load and increment enables from a small configuration register file.
- Each pass loads a start value and steps the counter at a prescaled rate until it reaches an end value.
- Passes repeat a programmed number of times, then a done pulse is raised.
- Sits between the top-level pin/config decode and the counter core.

Parameters:
WIDTH, 8, counter/data width
REP_W, 4, width of repeat register and pass counter
PRESC_W, 4, width of prescaler register

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
cfg_we  in  1  config write strobe
cfg_addr  in  2  0=START_VAL, 1=END_VAL, 2=REPEAT, 3=PRESC
cfg_wdata  in  WIDTH  config write data; REPEAT/PRESC use low bits
go  in  1  start sequence (level sampled per cycle)
abort  in  1  terminate sequence
cnt_val  in  WIDTH  current counter value (feedback)
cnt_load_en  out  1  counter synchronous load enable
cnt_load_val  out  WIDTH  value to load
cnt_inc_en  out  1  counter increment enable
busy  out  1  high in any state except IDLE
wrap  out  1  one-cycle pulse at end of each pass
done  out  1  one-cycle pulse at sequence completion
pass_cnt  out  REP_W  completed passes in current/last sequence

Behaviour:
- Interface: single clock clk; rst asynchronous, active-high. While rst is high:
  - state=IDLE; all outputs 0; pass_cnt=0.
  - Registers: START_VAL=0, END_VAL=all-ones, REPEAT=1, PRESC=0.
- Reset mid-sequence aborts immediately. Counter contents are not touched by this block.
- Outputs are Moore-decoded from the registered state. cnt_load_val always equals START_VAL.
- Counter contract: a load or increment enabled in cycle N is visible on cnt_val in cycle N+1.
- Config writes take effect only in IDLE and are ignored while busy. A write and go in the same IDLE cycle: the write lands and the sequence uses the new value.
- IDLE:
  - go=1 and abort=0 -> LOAD; pass_cnt cleared to 0.
- LOAD:
  - cnt_load_en=1 for exactly one cycle; prescaler cleared.
  - -> RUN.
- RUN:
  - Prescaler counts 0..PRESC; a tick occurs when prescaler==PRESC, then it returns to 0. Ticks therefore fall every PRESC+1 cycles, the first one PRESC cycles after RUN entry.
  - On a tick with cnt_val!=END_VAL: cnt_inc_en=1 for that cycle.
  - On a tick with cnt_val==END_VAL: no increment; -> WRAP.
  - Counter arithmetic is modulo 2^WIDTH. END_VAL<START_VAL is legal and passes through wrap-around (0xFF->0x00).
  - START_VAL==END_VAL yields zero increments per pass.
- WRAP:
  - wrap=1 for one cycle; pass_cnt increments, saturating at all-ones.
  - REPEAT!=0 and new pass_cnt==REPEAT -> DONE; otherwise -> LOAD.
  - REPEAT=0 means repeat forever until abort.
- DONE:
  - done=1 for one cycle -> IDLE. pass_cnt holds its value until the next accepted go.
- abort:
  - Highest priority in every non-IDLE state: next state IDLE, no wrap/done pulse, pass_cnt holds.
  - abort in IDLE is a no-op. go and abort together in IDLE: stay IDLE.
- go while busy is ignored. No queuing.

Optional Feature:
COUNTER_SEQ_PAUSE_EN
- Defined: adds input port pause (1 bit).
  - While pause=1 in RUN: prescaler frozen, cnt_inc_en=0, no transition out of RUN except on abort.
  - Prescaler phase resumes where it stopped.
  - pause has no effect in other states.
- Undefined: port absent; behaviour as above.

Decomposition:
- Package counter_seq_pkg:
  - state enum (IDLE, LOAD, RUN, WRAP, DONE)
  - cfg address constants (CFG_START=0, CFG_END=1, CFG_REPEAT=2, CFG_PRESC=3)
  - register reset-value constants
- Sub-module counter_seq_presc: prescaler tick generator with clear, freeze and PRESC inputs, and a tick output. Instanced once.

Test Plan:
- Basic run: START=3, END=5, PRESC=0, REPEAT=1; go -> one load of 3, cnt_inc_en on 2 cycles (cnt_val 3,4), wrap then done on consecutive cycles, pass_cnt=1, busy high for 6 cycles.
- Prescale + repeat: START=0, END=2, PRESC=3, REPEAT=3 -> increments spaced exactly 4 cycles apart; 3 loads, 3 wrap pulses, 1 done, pass_cnt=3.
- Wrap-around: START=0xFE, END=0x01, PRESC=0, REPEAT=1 -> cnt_val sequence FE,FF,00,01; 3 increments then done.
- Abort mid-RUN at second increment with REPEAT=0 -> next cycle IDLE, busy=0, no done/wrap, pass_cnt unchanged. An async rst pulse mid-RUN zeroes all outputs immediately and restores register defaults.
- Config gating: write END=0x10 while busy -> ignored (sequence ends at old END). Write START=7 in the same cycle as go in IDLE -> cnt_load_val=7 in LOAD.
- COUNTER_SEQ_PAUSE_EN: pause held 5 cycles during RUN with PRESC=2 -> no cnt_inc_en during pause, tick spacing measured across the pause = 3 + 5 cycles.
